// File: rtl/systolic_processing_element.sv
`default_nettype none
// ============================================================================
// Module  : systolic_processing_element
// Brief   : One MAC tile of a 2-D systolic array; forwards a/b, emits c+a*b.
// Revision: 1.0 - initial release
// ============================================================================
module systolic_processing_element #(
    parameter int WIDTH    = 8,
    parameter bit SIGNED   = 1'b0,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] c_in,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] c_out
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int SUM_W  = 2 * WIDTH + 1;

    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]  w_sum;
    logic [WIDTH-1:0]  w_mac;

    logic [WIDTH-1:0]  a_d, b_d, c_d;
    logic [WIDTH-1:0]  a_q, b_q, c_q;

    // Operands are extended to full product width so the low 2*WIDTH bits
    // of an unsigned multiply equal the two's-complement product.
    always_comb begin
        w_a_ext = {{WIDTH{SIGNED & a_in[WIDTH-1]}}, a_in};
        w_b_ext = {{WIDTH{SIGNED & b_in[WIDTH-1]}}, b_in};
        w_prod  = w_a_ext * w_b_ext;
        w_sum   = {SIGNED & w_prod[PROD_W-1], w_prod}
                + {{(SUM_W-WIDTH){SIGNED & c_in[WIDTH-1]}}, c_in};
        w_mac   = w_sum[WIDTH-1:0];
        if (SATURATE) begin
            if (SIGNED) begin
                // In range only when every bit above the result sign matches it.
                if (!(&w_sum[SUM_W-1:WIDTH-1]) && (|w_sum[SUM_W-1:WIDTH-1])) begin
                    w_mac = w_sum[SUM_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end else if (|w_sum[SUM_W-1:WIDTH]) begin
                w_mac = '1;
            end
        end
    end

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        if (en) begin
            a_d = a_in;
            b_d = b_in;
            c_d = w_mac;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign c_out = c_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_processing_element.sv
`default_nettype none
// ============================================================================
// Module  : tb_systolic_processing_element
// Brief   : Bench for four parameterisations of the systolic MAC element.
// Revision: 1.0 - initial release
// ============================================================================
module tb_systolic_processing_element;

    // Index 0: unsigned wrap, 1: unsigned sat, 2: signed sat, 3: signed wrap
    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] a_in, b_in, c_in;
    logic [7:0] ao [4];
    logic [7:0] bo [4];
    logic [7:0] co [4];

    logic [7:0] ea, eb;
    logic [7:0] ec [4];
    int n_checks;
    int n_fail;

    systolic_processing_element #(.WIDTH(8), .SIGNED(1'b0), .SATURATE(1'b0)) u_uw (
        .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .a_out(ao[0]), .b_out(bo[0]), .c_out(co[0]));
    systolic_processing_element #(.WIDTH(8), .SIGNED(1'b0), .SATURATE(1'b1)) u_us (
        .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .a_out(ao[1]), .b_out(bo[1]), .c_out(co[1]));
    systolic_processing_element #(.WIDTH(8), .SIGNED(1'b1), .SATURATE(1'b1)) u_ss (
        .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .a_out(ao[2]), .b_out(bo[2]), .c_out(co[2]));
    systolic_processing_element #(.WIDTH(8), .SIGNED(1'b1), .SATURATE(1'b0)) u_sw (
        .clk(clk), .rst(rst), .en(en), .a_in(a_in), .b_in(b_in), .c_in(c_in),
        .a_out(ao[3]), .b_out(bo[3]), .c_out(co[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer MAC, then clamp or keep the low byte.
    function automatic logic [7:0] model(int k, logic [7:0] a, logic [7:0] b, logic [7:0] c);
        bit sg = (k >= 2);
        bit st = (k == 1) || (k == 2);
        int av = int'(a);
        int bv = int'(b);
        int cv = int'(c);
        int s;
        if (sg) begin
            if (a[7]) av -= 256;
            if (b[7]) bv -= 256;
            if (c[7]) cv -= 256;
        end
        s = cv + av * bv;
        if (st) begin
            if (sg) begin
                if (s < -128) s = -128;
                if (s > 127)  s = 127;
            end else begin
                if (s > 255)  s = 255;
            end
        end
        return s[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst && en) begin
            ea = a_in;
            eb = b_in;
            for (int k = 0; k < 4; k++) ec[k] = model(k, a_in, b_in, c_in);
        end
        #1;
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        ea  = 8'h00;
        eb  = 8'h00;
        for (int k = 0; k < 4; k++) ec[k] = 8'h00;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({ao[k], bo[k], co[k]} !== 24'h0) begin
                n_fail++;
                $display("FAIL reset_init dut%0d: got %h/%h/%h want 00/00/00", k, ao[k], bo[k], co[k]);
            end
        end
        rst = 1'b1; en = 1'b1; a_in = 8'h5A; b_in = 8'h3C; c_in = 8'h21;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({ao[k], bo[k], co[k]} !== {ea, eb, ec[k]}) begin
                n_fail++;
                $display("FAIL reset_load dut%0d: got %h/%h/%h want %h/%h/%h", k, ao[k], bo[k], co[k], ea, eb, ec[k]);
            end
        end
        #2 assert_reset();
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({ao[k], bo[k], co[k]} !== 24'h0) begin
                n_fail++;
                $display("FAIL reset_async dut%0d: got %h/%h/%h want 00/00/00", k, ao[k], bo[k], co[k]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            a_in = 8'($urandom); b_in = 8'($urandom); c_in = 8'($urandom);
            tick();
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if ({ao[k], bo[k], co[k]} !== 24'h0) begin
                    n_fail++;
                    $display("FAIL reset_hold dut%0d: got %h/%h/%h want 00/00/00", k, ao[k], bo[k], co[k]);
                end
            end
        end
    endtask

    task automatic test_enable_low();
        logic [7:0] pa [3] = '{8'h55, 8'h12, 8'h94};
        logic [7:0] pb [3] = '{8'h33, 8'h2E, 8'h77};
        rst = 1'b1; en = 1'b0; c_in = 8'h04;
        for (int i = 0; i < 3; i++) begin
            a_in = pa[i]; b_in = pb[i];
            tick();
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if ({ao[k], bo[k], co[k]} !== 24'h0) begin
                    n_fail++;
                    $display("FAIL enable_low dut%0d: got %h/%h/%h want 00/00/00", k, ao[k], bo[k], co[k]);
                end
            end
        end
    endtask

    task automatic test_unsigned_wrap();
        logic [7:0] pa [4] = '{8'h55, 8'h12, 8'h94, 8'h00};
        logic [7:0] pb [4] = '{8'h33, 8'h2E, 8'h77, 8'h00};
        logic [7:0] pc [4] = '{8'hF3, 8'h40, 8'hD0, 8'h04};
        en = 1'b1; c_in = 8'h04;
        for (int i = 0; i < 4; i++) begin
            a_in = pa[i]; b_in = pb[i];
            tick();
            n_checks++;
            if ({ao[0], bo[0], co[0]} !== {pa[i], pb[i], pc[i]}) begin
                n_fail++;
                $display("FAIL wrap_pair%0d: got %h/%h/%h want %h/%h/%h", i, ao[0], bo[0], co[0], pa[i], pb[i], pc[i]);
            end
            for (int k = 1; k < 4; k++) begin
                n_checks++;
                if ({ao[k], bo[k], co[k]} !== {ea, eb, ec[k]}) begin
                    n_fail++;
                    $display("FAIL wrap_model dut%0d: got %h/%h/%h want %h/%h/%h", k, ao[k], bo[k], co[k], ea, eb, ec[k]);
                end
            end
        end
    endtask

    task automatic test_freeze();
        en = 1'b1; c_in = 8'h04;
        a_in = 8'h55; b_in = 8'h33; tick();
        a_in = 8'h12; b_in = 8'h2E; tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in = 8'($urandom); b_in = 8'($urandom); c_in = 8'($urandom);
            tick();
            n_checks++;
            if ({ao[0], bo[0], co[0]} !== 24'h122E40) begin
                n_fail++;
                $display("FAIL freeze_hold: got %h/%h/%h want 12/2e/40", ao[0], bo[0], co[0]);
            end
        end
        en = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({ao[k], bo[k], co[k]} !== {ea, eb, ec[k]}) begin
                n_fail++;
                $display("FAIL freeze_resume dut%0d: got %h/%h/%h want %h/%h/%h", k, ao[k], bo[k], co[k], ea, eb, ec[k]);
            end
        end
    endtask

    task automatic test_saturation();
        en = 1'b1;
        c_in = 8'h04; a_in = 8'h55; b_in = 8'h33; tick();
        n_checks++;
        if (co[1] !== 8'hFF) begin n_fail++; $display("FAIL sat_unsigned_hi: got %h want ff", co[1]); end
        a_in = 8'h01; b_in = 8'h02; tick();
        n_checks++;
        if (co[1] !== 8'h06) begin n_fail++; $display("FAIL sat_unsigned_in: got %h want 06", co[1]); end
        a_in = 8'h94; b_in = 8'h77; tick();
        n_checks++;
        if (co[2] !== 8'h80) begin n_fail++; $display("FAIL sat_signed_lo: got %h want 80", co[2]); end
        n_checks++;
        if (co[3] !== 8'hD0) begin n_fail++; $display("FAIL wrap_signed: got %h want d0", co[3]); end
        c_in = 8'h7F; a_in = 8'h7F; b_in = 8'h7F; tick();
        n_checks++;
        if (co[2] !== 8'h7F) begin n_fail++; $display("FAIL sat_signed_hi: got %h want 7f", co[2]); end
    endtask

    task automatic test_signed_in_range();
        en = 1'b1; a_in = 8'hFE; b_in = 8'h03; c_in = 8'h0A;
        tick();
        for (int k = 2; k < 4; k++) begin
            n_checks++;
            if (co[k] !== 8'h04) begin
                n_fail++;
                $display("FAIL signed_in_range dut%0d: got %h want 04", k, co[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (!rst) rst = 1'b1;
            en   = ($urandom_range(0, 4) != 0);
            a_in = 8'($urandom); b_in = 8'($urandom); c_in = 8'($urandom);
            if ($urandom_range(0, 39) == 0) assert_reset();
            tick();
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if ({ao[k], bo[k], co[k]} !== {ea, eb, ec[k]}) begin
                    n_fail++;
                    $display("FAIL random dut%0d it%0d: got %h/%h/%h want %h/%h/%h", k, i, ao[k], bo[k], co[k], ea, eb, ec[k]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        en = 1'b0; a_in = 8'h00; b_in = 8'h00; c_in = 8'h00;
        assert_reset();
        @(posedge clk); @(posedge clk); #1;
        test_reset();
        test_enable_low();
        test_unsigned_wrap();
        test_freeze();
        test_saturation();
        test_signed_in_range();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_processing_element.md
# systolic_processing_element

Multiply-accumulate processing element, one tile of a 2-D systolic array for matrix multiplication. Operand `a` streams horizontally and operand `b` vertically; each is re-registered and forwarded to the neighbouring PE. The partial sum `c` enters from the upstream PE and leaves registered as `c_in + a_in*b_in`. All state advances only when `en` is high.

## Interface
- `WIDTH`, default 8: width of a, b and c data paths.
- `SIGNED`, default 0: 0 means operands and sums are unsigned; 1 means two's complement.
- `SATURATE`, default 0: 0 means the sum wraps modulo 2^WIDTH; 1 means it clamps to the representable range.

Clock and reset are fixed for this block: one clock, `clk`; reset `rst` is asynchronous and active-low.

- `clk` input 1: rising-edge clock, the only clock domain.
- `rst` input 1: asynchronous active-low reset; clears all registers.
- `en` input 1: synchronous enable; when 0, all registers hold.
- `a_in` input WIDTH: horizontal operand from the west neighbour.
- `b_in` input WIDTH: vertical operand from the north neighbour.
- `c_in` input WIDTH: incoming partial sum.
- `a_out` output WIDTH: registered `a_in`, to the east neighbour.
- `b_out` output WIDTH: registered `b_in`, to the south neighbour.
- `c_out` output WIDTH: registered `c_in + a_in*b_in`.

## Operation
- Datapath registers are `a_q`, `b_q` and `c_q`, driving `a_out`, `b_out` and `c_out` directly. No combinational path runs from input to output.
- On a rising `clk` edge with `rst`=1 and `en`=1:
  - `a_q` ← `a_in`
  - `b_q` ← `b_in`
  - `c_q` ← f(`c_in` + `a_in`×`b_in`)
- On a rising `clk` edge with `en`=0, all registers keep their value.
- Arithmetic:
  - Compute the product at full 2·WIDTH width and the sum at 2·WIDTH+1 width, with sign extension when SIGNED=1.
  - SATURATE=0: f() takes the low WIDTH bits (wrap).
  - SATURATE=1, unsigned: clamp to [0, 2^WIDTH−1].
  - SATURATE=1, signed: clamp to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- No internal state beyond the three registers. There is no FSM; the element is a pure pipeline stage.

## Timing
- Reset:
  - `rst`=0 forces `a_out`, `b_out` and `c_out` to 0 immediately, without waiting for a clock edge.
  - Outputs stay 0 while `rst` is low, regardless of `en` or the data inputs.
- Release: the first capture happens on the first rising edge after `rst` goes high, provided `en`=1.
- Latency: 1 clock from the inputs to all three outputs. Throughput is one operation per enabled cycle.
- Enable: `en` is sampled on the same edge as the data. Toggling `en` mid-stream freezes the outputs at the last captured values, and capture resumes on the next edge with `en`=1.
- Reset during operation clears everything asynchronously. Operands in flight are discarded, and nothing is captured on an edge that coincides with `rst`=0.
- Inputs must be stable around the rising edge. The multiply and add form one combinational stage that must fit in one clock period.

## Test plan
All scenarios use the default WIDTH=8 unless stated otherwise.
- **Reset.** Drive `rst`=0 mid-cycle while the outputs are nonzero → all outputs become 0x00 at once. Hold `rst`=0 with `en`=1 and toggling inputs → outputs stay 0x00.
- **Enable low.** Release reset with `en`=0, `c_in`=4, and stream a/b = (0x55,0x33), (0x12,0x2E), (0x94,0x77) → outputs stay 0x00.
- **Unsigned wrap (defaults).** `en`=1, `c_in`=4, same stream, one pair per cycle. One cycle after each pair:
  - `a_out`/`b_out` equal that pair.
  - `c_out` is 0xF3, then 0x40, then 0xD0.
  - Then drive a=b=0 → `c_out`=0x04.
- **Freeze.** Drop `en` after the second pair while the inputs keep changing → `a_out`=0x12, `b_out`=0x2E, `c_out`=0x40 hold. Raise `en` again → the next edge captures the current inputs.
- **Saturation.**
  - SATURATE=1, SIGNED=0, `c_in`=4, a=0x55, b=0x33 → `c_out`=0xFF.
  - a=0x01, b=0x02 → `c_out`=0x06.
  - SIGNED=1, SATURATE=1, a=0x94 (−108), b=0x77 (119), `c_in`=4 → `c_out`=0x80.
  - Same values with SATURATE=0 → `c_out`=0xD0.
- **Signed, in range.** SIGNED=1, a=0xFE (−2), b=0x03, `c_in`=0x0A → `c_out`=0x04.
